// File: rtl/apb_burst_master.sv
// apb_burst_master: turns a {addr, len, dir} command into a sequence of
// single APB transfers, one beat per SETUP/ACCESS pair. Write data is pulled
// from a valid/ready stream, read data is pushed into a valid/ready stream.
// Each beat has its own ACCESS-phase timeout.
module apb_burst_master #(
    parameter int TIMEOUT = 256,
    parameter int LEN_W   = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    // command
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    // write data stream
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    // read data stream
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,
    output logic             rd_err,
    // completion
    output logic             done,
    output logic             done_err,
    output logic [LEN_W:0]   done_beats,
    // APB master
    output logic [31:0]      PADDR,
    output logic [31:0]      PWDATA,
    output logic             PWRITE,
    output logic             PSEL,
    output logic             PENABLE,
    input  logic [31:0]      PRDATA,
    input  logic             PREADY,
    input  logic             PSLVERR
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               write_q, write_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W:0]     beats_q, beats_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               rd_valid_q, rd_valid_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               rd_err_q, rd_err_d;
    logic               done_q, done_d;
    logic               done_err_q, done_err_d;
    logic [LEN_W:0]     done_beats_q, done_beats_d;

    logic               last_beat;

    // beats_q counts completed beats, so it equals len when the final beat is in flight
    assign last_beat = (beats_q == {1'b0, len_q});

    // state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // next state, handshakes and next values of every datapath register
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        len_d        = len_q;
        beats_d      = beats_q;
        err_d        = err_q;
        tmo_d        = tmo_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        rd_err_d     = rd_err_q;
        done_err_d   = done_err_q;
        done_beats_d = done_beats_q;
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;

        // read stream drains on its own, independent of where the burst is
        if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr & 32'hFFFF_FFFC;
                    write_d = cmd_write;
                    len_d   = cmd_len;
                    beats_d = '0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (write_q) begin
                    // data must be in hand before the bus is claimed
                    if (wr_valid) begin
                        wr_ready = 1'b1;
                        wdata_d  = wr_data;
                        state_d  = S_SETUP;
                    end
                end else if (!rd_valid_q) begin
                    // only one read word of buffering: wait until it is taken
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                tmo_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    beats_d = beats_q + 1'b1;
                    if (!write_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = PRDATA;
                        rd_err_d   = PSLVERR;
                    end
                    if (PSLVERR) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 32'd4;
                        state_d = S_REQ;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // this is the TIMEOUT-th ACCESS cycle without PREADY
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // APB and completion outputs are registered off the next state
        psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d = (state_d == S_ACCESS);
        done_d    = (state_d == S_DONE);
        if (state_d == S_DONE) begin
            done_err_d   = err_d;
            done_beats_d = beats_d;
        end
    end

    // datapath and registered outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            len_q        <= '0;
            beats_q      <= '0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_err_q     <= 1'b0;
            done_q       <= 1'b0;
            done_err_q   <= 1'b0;
            done_beats_q <= '0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            len_q        <= len_d;
            beats_q      <= beats_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_err_q     <= rd_err_d;
            done_q       <= done_d;
            done_err_q   <= done_err_d;
            done_beats_q <= done_beats_d;
        end
    end

    assign PADDR      = addr_q;
    assign PWDATA     = wdata_q;
    assign PWRITE     = write_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_err     = rd_err_q;
    assign done       = done_q;
    assign done_err   = done_err_q;
    assign done_beats = done_beats_q;

endmodule

// File: tb/tb_apb_burst_master.sv
// Bench for apb_burst_master: a table of bursts run against a small APB slave
// model, plus hand-written reset sequences.
module tb_apb_burst_master;

    localparam int LEN_W = 8;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wr_valid, wr_ready;
    logic [31:0]      wr_data;
    logic             rd_valid, rd_ready, rd_err;
    logic [31:0]      rd_data;
    logic             done, done_err;
    logic [LEN_W:0]   done_beats;
    logic [31:0]      PADDR, PWDATA, PRDATA;
    logic             PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    int tests = 0;
    int fails = 0;

    apb_burst_master #(.TIMEOUT(256), .LEN_W(LEN_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_err(rd_err),
        .done(done), .done_err(done_err), .done_beats(done_beats),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string            name;
        bit               write;
        logic [31:0]      addr;
        logic [LEN_W-1:0] len;
        int               err_beat;   // beat index answered with PSLVERR, -1 none
        int               waits;      // PREADY-low ACCESS cycles per beat
        int               rd_stall;   // rd_ready low this long after first rd_valid
        int               gap;        // wr_valid low this long after each write beat
        bit               exp_err;
        int               exp_beats;
        int               exp_cyc;    // done cycle, acceptance = cycle 0
        int               exp_setups;
        int               exp_wr;
        int               exp_reads;
        int               exp_acc;
    } vec_t;

    function automatic vec_t mk(string n, bit w, logic [31:0] a, int len, int eb,
                                int wt, int st, int gp, bit ee, int ebt, int ec,
                                int es, int ew, int er, int ea);
        vec_t v;
        v.name = n; v.write = w; v.addr = a; v.len = LEN_W'(len); v.err_beat = eb;
        v.waits = wt; v.rd_stall = st; v.gap = gp; v.exp_err = ee; v.exp_beats = ebt;
        v.exp_cyc = ec; v.exp_setups = es; v.exp_wr = ew; v.exp_reads = er; v.exp_acc = ea;
        return v;
    endfunction

    function automatic logic [31:0] rdpat(int i);
        return 32'(32'h11 * (i + 1));
    endfunction

    function automatic logic [31:0] wdpat(int i);
        return 32'(32'hDEADBEEF ^ (32'h01010101 * i));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Runs one burst; called at posedge+1 with the DUT idle.
    task automatic run_burst(input vec_t v);
        int cyc, dcyc, setups, acc, acc_beat, beat, wr_hs, reads, gap, stall;
        bit stall_armed, got_done;
        logic [31:0] base, exp_addr;
        base = v.addr & 32'hFFFF_FFFC;
        cyc = 1; dcyc = -1; setups = 0; acc = 0; acc_beat = 0; beat = 0;
        wr_hs = 0; reads = 0; gap = 0; stall = 0; stall_armed = 0; got_done = 0;

        check({v.name, ".cmd_ready"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len;
        tick();
        // scramble the command inputs: they must not matter after acceptance
        cmd_valid = 1'b0; cmd_write = ~v.write; cmd_addr = $urandom; cmd_len = LEN_W'($urandom);

        while (cyc < 2000) begin
            if (done) begin
                got_done = 1; dcyc = cyc;
                check({v.name, ".done_err"}, 64'(done_err), 64'(v.exp_err));
                check({v.name, ".done_beats"}, 64'(done_beats), 64'(v.exp_beats));
                check({v.name, ".done_psel"}, 64'(PSEL), 64'(0));
            end
            if (PSEL && !PENABLE) begin
                exp_addr = base + 32'(4 * setups);
                check({v.name, ".paddr"}, 64'(PADDR), 64'(exp_addr));
                check({v.name, ".pwrite"}, 64'(PWRITE), 64'(v.write));
                if (v.write) check({v.name, ".pwdata"}, 64'(PWDATA), 64'(wdpat(setups)));
                else         check({v.name, ".setup_rdv"}, 64'(rd_valid), 64'(0));
                setups++;
                acc_beat = 0;
            end
            // write stream
            if (gap > 0) begin
                wr_valid = 1'b0;
                gap--;
                check({v.name, ".gap_psel"}, 64'(PSEL), 64'(0));
            end else begin
                wr_valid = v.write && !got_done;
            end
            wr_data = wr_valid ? wdpat(wr_hs) : 32'hBAD0BAD0;
            // slave
            PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hDEAD0000;
            if (PSEL && PENABLE) begin
                acc++;
                if (acc_beat >= v.waits) begin
                    PREADY = 1'b1;
                    PSLVERR = (beat == v.err_beat);
                    PRDATA = rdpat(beat);
                    beat++;
                    if (v.write) gap = v.gap;
                end
                acc_beat++;
            end
            // read stream
            if (rd_valid && !stall_armed) begin
                stall_armed = 1; stall = v.rd_stall;
            end
            if (rd_valid && stall > 0) begin
                rd_ready = 1'b0; stall--;
            end else begin
                rd_ready = 1'b1;
            end
            #1;
            if (wr_ready) wr_hs++;
            if (rd_valid && rd_ready) begin
                check({v.name, ".rd_data"}, 64'(rd_data), 64'(rdpat(reads)));
                check({v.name, ".rd_err"}, 64'(rd_err), 64'(reads == v.err_beat));
                reads++;
            end
            @(posedge HCLK); #1;
            cyc++;
            if (got_done && !rd_valid) break;
        end
        wr_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; rd_ready = 1'b1;

        check({v.name, ".done_seen"}, 64'(got_done), 64'(1));
        check({v.name, ".done_cyc"}, 64'(dcyc), 64'(v.exp_cyc));
        check({v.name, ".setups"}, 64'(setups), 64'(v.exp_setups));
        check({v.name, ".wr_hs"}, 64'(wr_hs), 64'(v.exp_wr));
        check({v.name, ".reads"}, 64'(reads), 64'(v.exp_reads));
        check({v.name, ".acc"}, 64'(acc), 64'(v.exp_acc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int n;
        tbl[0] = mk("wr1",        1, 32'h1A100000, 0, -1,      0, 0, 0, 0, 1,   4, 1, 1, 0,   1);
        tbl[1] = mk("rd4_stall",  0, 32'h00000000, 3, -1,      0, 5, 0, 0, 4,  21, 4, 0, 4,   4);
        tbl[2] = mk("wr_slverr",  1, 32'h00002000, 3,  1,      0, 0, 0, 1, 2,   7, 2, 2, 0,   2);
        tbl[3] = mk("rd_timeout", 0, 32'h00003000, 0, -1, 100000, 0, 0, 1, 0, 259, 1, 0, 0, 256);
        tbl[4] = mk("wr_wrap",    1, 32'hFFFFFFFC, 1, -1,      0, 0, 3, 0, 2,  10, 2, 2, 0,   2);
        tbl[5] = mk("rd_wait",    0, 32'h00000103, 2, -1,      2, 0, 0, 0, 3,  18, 3, 0, 3,   9);
        tbl[6] = mk("wr_lasterr", 1, 32'h00000400, 2,  2,      1, 0, 0, 1, 3,  13, 3, 3, 0,   6);
        tbl[7] = mk("rd_err",     0, 32'h00000500, 1,  0,      0, 0, 0, 1, 1,   4, 1, 0, 1,   1);

        HRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst.psel", 64'(PSEL), 64'(0));
        check("rst.penable", 64'(PENABLE), 64'(0));
        check("rst.pwrite", 64'(PWRITE), 64'(0));
        check("rst.paddr", 64'(PADDR), 64'(0));
        check("rst.pwdata", 64'(PWDATA), 64'(0));
        check("rst.rd_valid", 64'(rd_valid), 64'(0));
        check("rst.rd_data", 64'({rd_err, rd_data}), 64'(0));
        check("rst.done", 64'({done, done_err, done_beats}), 64'(0));
        HRESETn = 1'b1;
        tick();
        check("idle.cmd_ready", 64'(cmd_ready), 64'(1));

        for (int i = 0; i < 8; i++) run_burst(tbl[i]);

        // reset in the middle of an ACCESS phase of a 4-beat read
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_len = LEN_W'(3);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!(PSEL && PENABLE) && n < 10) begin
            tick();
            n++;
        end
        check("midrst.reach_access", 64'(PSEL && PENABLE), 64'(1));
        #3;
        HRESETn = 1'b0;
        #1;
        check("midrst.psel_async", 64'(PSEL), 64'(0));
        check("midrst.penable_async", 64'(PENABLE), 64'(0));
        repeat (2) begin
            @(posedge HCLK); #1;
            check("midrst.no_done", 64'(done), 64'(0));
        end
        HRESETn = 1'b1;
        tick();
        check("midrst.cmd_ready", 64'(cmd_ready), 64'(1));
        check("midrst.bus_idle", 64'({PSEL, PENABLE}), 64'(0));
        check("midrst.done_after", 64'(done), 64'(0));

        // the block must come back fully usable
        run_burst(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_burst_master.md
APB_BURST_MASTER -- requirements
Module: apb_burst_master

Interface
REQ-001 Parameter TIMEOUT, default 256: maximum ACCESS-phase cycles per beat before abort.
REQ-002 Parameter LEN_W, default 8: width of cmd_len.
REQ-003 The reset is HRESETn, asynchronous, active-low, and the clock is HCLK.
REQ-004 HCLK  in  1  clock; all logic on rising edge.
REQ-005 HRESETn  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  / cmd_ready  out  1  command handshake.
REQ-007 cmd_write  in  1  burst direction: 1 = write, 0 = read.
REQ-008 cmd_addr  in  32  first beat byte address, word aligned (bits [1:0] ignored, driven 0 on PADDR).
REQ-009 cmd_len  in  LEN_W  beats minus one; 0 = 1 beat, max 2^LEN_W beats.
REQ-010 wr_valid  in  1  / wr_ready  out  1  / wr_data  in  32  write data stream.
REQ-011 rd_valid  out  1  / rd_ready  in  1  / rd_data  out  32  / rd_err  out  1  read data stream.
REQ-012 done  out  1  one-cycle burst completion pulse; done_err  out  1  valid with done.
REQ-013 done_beats  out  LEN_W+1  beats completed with PREADY, valid with done.
REQ-014 PADDR out 32, PWDATA out 32, PWRITE out 1, PSEL out 1, PENABLE out 1: APB master outputs, all registered.
REQ-015 PRDATA in 32, PREADY in 1, PSLVERR in 1: APB slave response.

Function
REQ-016 States: IDLE, REQ, SETUP, ACCESS, DONE.
REQ-017 cmd_ready = 1 only in IDLE; on cmd_valid && cmd_ready the block latches addr/write/len, clears beat counter and error flag, and goes to REQ.
REQ-018 REQ, write: when wr_valid = 1, wr_ready = 1 that cycle (combinational), wr_data is latched into PWDATA, state -> SETUP; otherwise stay, PSEL = 0.
REQ-019 REQ, read: when rd_valid = 0, state -> SETUP; when rd_valid = 1, stay (no overwrite of undelivered data).
REQ-020 SETUP: PSEL = 1, PENABLE = 0, for exactly one cycle; state -> ACCESS.
REQ-021 ACCESS: PSEL = 1, PENABLE = 1, held until PREADY = 1 or timeout.
REQ-022 PADDR, PWRITE and PWDATA are constant from SETUP through the final ACCESS cycle of a beat.
REQ-023 ACCESS with PREADY = 1: beat counter increments. On a read, rd_data <= PRDATA, rd_err <= PSLVERR, rd_valid <= 1.
REQ-024 Completion with PSLVERR = 1 sets the error flag and goes to DONE; remaining beats are not issued, and unconsumed write data stays unconsumed.
REQ-025 Completion with no error on the last beat goes to DONE; otherwise PADDR += 4 (mod 2^32 wrap) and state -> REQ.
REQ-026 Timeout: a per-beat counter cleared in SETUP counts ACCESS cycles. When TIMEOUT cycles elapse without PREADY, the error flag is set and state -> DONE. That beat is not counted, and no rd_valid is produced for it.
REQ-027 DONE lasts one cycle: done = 1, done_err = error flag, done_beats = beat counter, PSEL = 0; state -> IDLE.
REQ-028 rd_valid clears on rd_valid && rd_ready, and holds with rd_data stable otherwise.
REQ-029 rd_valid is independent of the burst and may remain 1 after done.
REQ-030 PSEL = 0 in IDLE, REQ and DONE, so consecutive beats always return through REQ (minimum 3 cycles per beat).
REQ-031 Single write beat latency, with wr_valid high and PREADY high: accept at cycle 0, SETUP at cycle 2, ACCESS at cycle 3, done at cycle 4.
REQ-032 Input changes to cmd_* after acceptance have no effect until the next IDLE.

Reset
REQ-033 On HRESETn = 0, state = IDLE immediately (asynchronous).
REQ-034 On HRESETn = 0, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rd_valid, rd_err, rd_data, done, done_err and done_beats are 0, and all counters are cleared.
REQ-035 Reset mid-burst abandons the transfer with no done pulse; the bus is idle on the first cycle after reset deassertion.

Verification
REQ-036 Write, len = 0, addr 0x1A100000, wr_data 0xDEADBEEF, PREADY = 1 -> one SETUP/ACCESS pair at PADDR 0x1A100000, PWRITE = 1, PWDATA 0xDEADBEEF, done at cycle 4, done_err = 0, done_beats = 1.
REQ-037 Read, len = 3, addr 0x000, slave returns 0x11, 0x22, 0x33, 0x44, rd_ready held 0 for 5 cycles after the first beat -> PADDR 0x000/0x004/0x008/0x00C, second SETUP delayed until rd_valid clears, rd_data order preserved, done_beats = 4.
REQ-038 Write, len = 3, PSLVERR = 1 on beat 2 -> beat 3 not issued, wr_ready pulsed exactly 2 times, done_err = 1, done_beats = 2.
REQ-039 Read, PREADY stuck 0, TIMEOUT = 256 -> exactly 256 ACCESS cycles, then PSEL = 0, done_err = 1, done_beats = 0, no rd_valid.
REQ-040 Write, len = 1, addr 0xFFFFFFFC -> second beat PADDR 0x00000000; wr_valid gapped for 3 cycles before beat 2 -> PSEL held 0 in REQ meanwhile.
REQ-041 HRESETn asserted during ACCESS of a 4-beat burst -> PSEL/PENABLE drop without a clock edge, no done pulse, cmd_ready = 1 after release.
